// File: rtl/bus_host_arb_pkg.sv
// Shared types and helpers for the bus host arbiter: FSM state encoding and host-index width.
package bus_host_arb_pkg;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbHold = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_host_arb_id_fifo.sv
// In-order ID FIFO recording which host owns each accepted-but-unanswered transaction.
module bus_host_arb_id_fifo
  import bus_host_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           wdata,
  output logic [Width-1:0]           head,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Multi-host req/gnt/rvalid bus arbiter with in-order response routing.
// Define BUS_HOST_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module bus_host_arbiter
  import bus_host_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                host_req_i    [NrHosts],
  input  logic                                host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]              host_be_i     [NrHosts],
  input  logic [AddressWidth-1:0]             host_addr_i   [NrHosts],
  input  logic [DataWidth-1:0]                host_wdata_i  [NrHosts],
  output logic                                host_gnt_o    [NrHosts],
  output logic                                host_rvalid_o [NrHosts],
  output logic                                host_err_o    [NrHosts],
  output logic [DataWidth-1:0]                host_rdata_o  [NrHosts],
  output logic                                dev_req_o,
  output logic                                dev_we_o,
  output logic [DataWidth/8-1:0]              dev_be_o,
  output logic [AddressWidth-1:0]             dev_addr_o,
  output logic [DataWidth-1:0]                dev_wdata_o,
  input  logic                                dev_gnt_i,
  input  logic                                dev_rvalid_i,
  input  logic                                dev_err_i,
  input  logic [DataWidth-1:0]                dev_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                resp_unexpected_o
);

  localparam int unsigned IW = idx_width(NrHosts);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);

  arb_state_e      state;
  logic [IW-1:0]   held_idx, winner, sel_idx, head_idx;
  logic            any_req, found, present, accept, pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   count;

`ifdef BUS_HOST_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  int unsigned   cand;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       rr_ptr <= '0;
    else if (accept) rr_ptr <= (sel_idx == IW'(NrHosts - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < NrHosts; k++) begin
      cand = (32'(rr_ptr) + k) % NrHosts;
      if (!found && host_req_i[cand]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NrHosts; k++) begin
      if (!found && host_req_i[k]) begin
        found  = 1'b1;
        winner = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    any_req = 1'b0;
    for (int unsigned k = 0; k < NrHosts; k++) any_req |= host_req_i[k];
  end

  assign sel_idx = (state == ArbHold) ? held_idx : winner;
  assign pop     = dev_rvalid_i && !fifo_empty;
  // HOLD always keeps presenting: it can only be entered with room left, and nothing is accepted while held.
  assign present = !rst_i && ((state == ArbHold) || (any_req && (!fifo_full || pop)));
  assign accept  = present && dev_gnt_i;

  assign dev_req_o   = present;
  assign dev_we_o    = present && host_we_i[sel_idx];
  assign dev_be_o    = present ? host_be_i[sel_idx]    : '0;
  assign dev_addr_o  = present ? host_addr_i[sel_idx]  : '0;
  assign dev_wdata_o = present ? host_wdata_i[sel_idx] : '0;

  always_comb begin
    for (int unsigned k = 0; k < NrHosts; k++) begin
      host_gnt_o[k]    = accept && (sel_idx == IW'(k));
      host_rvalid_o[k] = !rst_i && pop && (head_idx == IW'(k));
      host_err_o[k]    = !rst_i && pop && (head_idx == IW'(k)) && dev_err_i;
      host_rdata_o[k]  = rst_i ? '0 : dev_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ArbIdle;
      held_idx <= '0;
    end else begin
      case (state)
        ArbIdle: if (present && !dev_gnt_i) begin
          state    <= ArbHold;
          held_idx <= winner;
        end
        ArbHold: if (dev_gnt_i) state <= ArbIdle;
        default: state <= ArbIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           resp_unexpected_o <= 1'b0;
    else if (dev_rvalid_i && fifo_empty) resp_unexpected_o <= 1'b1;
  end

  assign outstanding_o = count;

  bus_host_arb_id_fifo #(
    .Depth(MaxOutstanding),
    .Width(IW)
  ) u_id_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (accept),
    .pop  (pop),
    .wdata(sel_idx),
    .head (head_idx),
    .count(count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: expected host IDs queued on acceptance, checked on response.
module tb_bus_host_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req   [2];
  logic        host_we    [2];
  logic [3:0]  host_be    [2];
  logic [31:0] host_addr  [2];
  logic [31:0] host_wdata [2];
  logic        host_gnt   [2];
  logic        host_rvalid[2];
  logic        host_err   [2];
  logic [31:0] host_rdata [2];
  logic        dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
  logic [3:0]  dev_be;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic [1:0]  outstanding;
  logic        resp_unexpected;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          exp_q[$];
  logic        unexp_m = 1'b0;

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts(2),
    .DataWidth(32),
    .AddressWidth(32),
    .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
    .host_rdata_o(host_rdata),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_addr_o(dev_addr),
    .dev_wdata_o(dev_wdata), .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
    .dev_err_i(dev_err), .dev_rdata_i(dev_rdata),
    .outstanding_o(outstanding), .resp_unexpected_o(resp_unexpected)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, update the scoreboard, advance to next negedge.
  // win is the host expected on dev_*, or -1 when nothing should be presented.
  task automatic cyc(input logic r0, input logic r1, input logic g, input logic rv,
                     input logic er, input logic [31:0] rd, input int win);
    int h;
    host_req[0] = r0; host_req[1] = r1;
    dev_gnt = g; dev_rvalid = rv; dev_err = er; dev_rdata = rd;
    #1;
    check("dev_req", 64'(dev_req), 64'(win >= 0));
    check("outstanding", 64'(outstanding), 64'(exp_q.size()));
    check("unexpected", 64'(resp_unexpected), 64'(unexp_m));
    for (int i = 0; i < 2; i++)
      check($sformatf("gnt%0d", i), 64'(host_gnt[i]), 64'(g && (win == i)));
    if (win >= 0) begin
      check("dev_addr", 64'(dev_addr), 64'(host_addr[win]));
      check("dev_wdata", 64'(dev_wdata), 64'(host_wdata[win]));
      check("dev_be", 64'(dev_be), 64'(host_be[win]));
      check("dev_we", 64'(dev_we), 64'(host_we[win]));
    end
    if (rv && exp_q.size() > 0) begin
      h = exp_q.pop_front();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rvalid%0d", i), 64'(host_rvalid[i]), 64'(i == h));
        check($sformatf("err%0d", i), 64'(host_err[i]), 64'((i == h) && er));
      end
      check("rdata", 64'(host_rdata[h]), 64'(rd));
    end else begin
      if (rv) unexp_m = 1'b1;
      for (int i = 0; i < 2; i++)
        check($sformatf("rvalid%0d", i), 64'(host_rvalid[i]), 64'd0);
    end
    if (win >= 0 && g) exp_q.push_back(win);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 64'(dev_req), 64'd0);
    check({tag, "_addr"}, 64'(dev_addr), 64'd0);
    check({tag, "_wdata"}, 64'(dev_wdata), 64'd0);
    check({tag, "_out"}, 64'(outstanding), 64'd0);
    check({tag, "_unexp"}, 64'(resp_unexpected), 64'd0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_gnt%0d", tag, i), 64'(host_gnt[i]), 64'd0);
      check($sformatf("%s_rv%0d", tag, i), 64'(host_rvalid[i]), 64'd0);
      check($sformatf("%s_err%0d", tag, i), 64'(host_err[i]), 64'd0);
      check($sformatf("%s_rd%0d", tag, i), 64'(host_rdata[i]), 64'd0);
    end
  endtask

  initial begin
    host_we[0] = 1'b1; host_be[0] = 4'hF; host_addr[0] = 32'h1000_0000; host_wdata[0] = 32'h0000_1111;
    host_we[1] = 1'b0; host_be[1] = 4'h3; host_addr[1] = 32'h2000_0000; host_wdata[1] = 32'h0000_2222;

    // Reset holds all outputs low even with live stimulus.
    rst = 1'b1;
    host_req[0] = 1'b1; host_req[1] = 1'b1;
    dev_gnt = 1'b1; dev_rvalid = 1'b1; dev_err = 1'b1; dev_rdata = 32'hDEAD_BEEF;
    #3;
    check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    host_req[0] = 1'b0; host_req[1] = 1'b0;
    dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0; dev_rdata = '0;
    rst = 1'b0;

    // Both hosts requesting with an always-granting device.
`ifdef BUS_HOST_ARB_RR_EN
    cyc(1, 1, 1, 0, 0, 32'h1, 0);
    cyc(1, 1, 1, 1, 0, 32'h2, 1);
    cyc(1, 1, 1, 1, 0, 32'h3, 0);
    cyc(1, 1, 1, 1, 0, 32'h4, 1);
`else
    cyc(1, 1, 1, 0, 0, 32'h1, 0);
    cyc(1, 1, 1, 1, 0, 32'h2, 0);
    cyc(1, 1, 1, 1, 0, 32'h3, 0);
    cyc(1, 1, 1, 1, 0, 32'h4, 0);
`endif
    cyc(0, 0, 0, 1, 0, 32'h5, -1);

    // Host 1 stalled three cycles; host 0 arriving mid-hold must not steal the bus.
    cyc(0, 1, 0, 0, 0, 32'h0, 1);
    cyc(1, 1, 0, 0, 0, 32'h0, 1);
    cyc(1, 1, 0, 0, 0, 32'h0, 1);
    cyc(1, 1, 1, 0, 0, 32'h0, 1);
    cyc(1, 0, 1, 0, 0, 32'h0, 0);

    // Outstanding limit reached, then a same-cycle pop admits a new request.
    cyc(1, 1, 1, 0, 0, 32'h0, -1);
    cyc(1, 0, 1, 1, 0, 32'hA5A5_A5A5, 0);
    cyc(0, 0, 0, 1, 1, 32'h5A5A_5A5A, -1);
    cyc(0, 0, 0, 1, 0, 32'h0000_0077, -1);

    // Response with empty FIFO is dropped and sticks the error flag.
    cyc(0, 0, 0, 1, 0, 32'h0000_0088, -1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);

    // Asynchronous reset with two transactions in flight.
    cyc(0, 1, 1, 0, 0, 32'h0, 1);
    cyc(1, 0, 1, 0, 0, 32'h0, 0);
    host_req[0] = 1'b1; host_req[1] = 1'b1;
    dev_gnt = 1'b1; dev_rvalid = 1'b1; dev_err = 1'b1; dev_rdata = 32'hFFFF_FFFF;
    #1;
    check("pre_rst_out", 64'(outstanding), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    @(negedge clk);
    host_req[0] = 1'b0; host_req[1] = 1'b0;
    dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0; dev_rdata = '0;
    rst = 1'b0;
    exp_q.delete();
    unexp_m = 1'b0;

    // Pre-reset IDs are gone; arbitration restarts from host 0.
    cyc(0, 0, 0, 1, 0, 32'h0000_0099, -1);
    cyc(1, 1, 1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 0, 32'h0000_00AA, -1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
